memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the width of the data path.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 64, meaning the width of the address.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 2, meaning the number of cycles the memory command is held; legal range 1..15.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port if_req, input, 1 bit: fetch read request.
REQ-007 The block SHALL have port if_addr, input, ADDR_WIDTH bits: fetch address.
REQ-008 The block SHALL have ports if_gnt (output, 1 bit: fetch accepted), if_rvalid (output, 1 bit: fetch data valid pulse) and if_rdata (output, DATA_WIDTH bits: fetch read data).
REQ-009 The block SHALL have ports d_req (input, 1), d_we (input, 1: 1=write, 0=read), d_addr (input, ADDR_WIDTH) and d_wdata (input, DATA_WIDTH).
REQ-010 The block SHALL have ports d_gnt (output, 1), d_done (output, 1: completion pulse) and d_rdata (output, DATA_WIDTH).
REQ-011 The block SHALL have ports mem_read, mem_write (outputs, 1), mem_address (output, ADDR_WIDTH), mem_write_data (output, DATA_WIDTH) and mem_read_data (input, DATA_WIDTH).

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 In IDLE, if_gnt/d_gnt SHALL be combinational; at most one is high, and only when the corresponding req is high.
REQ-014 A transaction SHALL be accepted on the rising edge where req && gnt; address, d_we and d_wdata SHALL be latched, and the state SHALL move to BUSY with counter = MEM_LATENCY.
REQ-015 In BUSY, mem_read or mem_write (never both) SHALL be driven from registers together with the latched mem_address/mem_write_data; the counter SHALL decrement each cycle.
REQ-016 In the last BUSY cycle (counter==1), a read SHALL capture mem_read_data into the granted port's rdata register; the state SHALL then move to DONE.
REQ-017 DONE SHALL last one cycle: if_rvalid (fetch) or d_done (data, both reads and writes) is high for exactly that cycle; the next state is IDLE, and no grant is given in DONE.
REQ-018 Latency SHALL be: accept edge at cycle T, BUSY cycles T+1..T+MEM_LATENCY, completion pulse at cycle T+MEM_LATENCY+1; throughput is one transaction per MEM_LATENCY+2 cycles.
REQ-019 Outside BUSY, mem_read, mem_write, mem_address and mem_write_data SHALL be 0; mem_write_data SHALL also be 0 during reads.
REQ-020 A request dropped before grant SHALL cause no transaction; request inputs changing during BUSY/DONE SHALL be ignored.
REQ-021 if_rdata/d_rdata SHALL hold their value until the next read completion on that port; a d_we=1 completion leaves d_rdata unchanged.
REQ-022 The fetch port SHALL be read-only; mem_write is never driven by a fetch grant.

Reset
REQ-023 When reset_n=0, the block SHALL immediately force state IDLE, counter 0, all outputs 0 and the round-robin pointer to "fetch last served".
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction with no completion pulse; a grant is possible in the first cycle after reset_n rises.

Configuration
REQ-025 With macro MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be resolved round-robin: the port not served last wins, and the pointer updates on every accept.
REQ-026 Without MEM_ARB_ROUND_ROBIN_EN, the data port SHALL always win over fetch (fixed priority), and no pointer register exists.

Verification (MEM_LATENCY=2)
REQ-027 Fetch read: if_req=1, if_addr=5, memory returns 5 -> if_gnt at T; mem_read=1 and mem_address=5 in T+1..T+2; if_rvalid=1 and if_rdata=5 at T+3.
REQ-028 Data write: d_we=1, d_addr=7, d_wdata=0xAA -> mem_write=1 and mem_write_data=0xAA for 2 cycles; d_done pulse at T+3; d_rdata unchanged.
REQ-029 Both ports request continuously for 4 transactions -> with the macro: grants D,F,D,F; without the macro: D,D,D,D.
REQ-030 Apply reset_n=0 in the first BUSY cycle -> mem_read drops asynchronously; no if_rvalid/d_done pulse; grant is given in the first cycle after release.
REQ-031 Assert d_req for 1 cycle while BUSY serving fetch, then drop it -> no data transaction, and mem_address never equals d_addr.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single fixed-latency memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-fetch priority.
module memory_arbiter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_reg;
  logic [3:0]            cnt_reg;
  logic                  sel_data_reg;
  logic                  mem_read_reg;
  logic                  mem_write_reg;
  logic [ADDR_WIDTH-1:0] mem_address_reg;
  logic [DATA_WIDTH-1:0] mem_write_data_reg;
  logic [DATA_WIDTH-1:0] if_rdata_reg;
  logic [DATA_WIDTH-1:0] d_rdata_reg;
  logic                  if_rvalid_reg;
  logic                  d_done_reg;
  logic                  idle;
  logic                  d_win;
  logic                  accept;

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign idle = reset_n && (state_reg == IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_reg;  // 1 = data port served last

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      last_data_reg <= 1'b0;
    else if (accept)
      last_data_reg <= d_gnt;
  end

  assign d_win = d_req && (!if_req || !last_data_reg);
`else
  assign d_win = d_req;
`endif

  assign d_gnt  = idle && d_win;
  assign if_gnt = idle && if_req && !d_win;
  assign accept = d_gnt || if_gnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      cnt_reg            <= 4'd0;
      sel_data_reg       <= 1'b0;
      mem_read_reg       <= 1'b0;
      mem_write_reg      <= 1'b0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= '0;
      if_rdata_reg       <= '0;
      d_rdata_reg        <= '0;
      if_rvalid_reg      <= 1'b0;
      d_done_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg          <= BUSY;
            cnt_reg            <= 4'(MEM_LATENCY);
            sel_data_reg       <= d_gnt;
            mem_read_reg       <= if_gnt || !d_we;
            mem_write_reg      <= d_gnt && d_we;
            mem_address_reg    <= d_gnt ? d_addr : if_addr;
            mem_write_data_reg <= (d_gnt && d_we) ? d_wdata : '0;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= DONE;
            if (mem_read_reg) begin
              if (sel_data_reg)
                d_rdata_reg <= mem_read_data;
              else
                if_rdata_reg <= mem_read_data;
            end
            if_rvalid_reg      <= !sel_data_reg;
            d_done_reg         <= sel_data_reg;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= '0;
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          if_rvalid_reg <= 1'b0;
          d_done_reg    <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_read       = mem_read_reg;
  assign mem_write      = mem_write_reg;
  assign mem_address    = mem_address_reg;
  assign mem_write_data = mem_write_data_reg;
  assign if_rdata       = if_rdata_reg;
  assign d_rdata        = d_rdata_reg;
  assign if_rvalid      = if_rvalid_reg;
  assign d_done         = d_done_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (MEM_LATENCY=2); the memory returns its address as data.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic        d_gnt, d_done;
  logic [63:0] d_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  int vectors    = 0;
  int miscompares = 0;

  memory_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MEM_LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = mem_address;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic exp_data;
    reset_n = 1'b0; if_req = 1'b1; if_addr = 64'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0;
    step(); step();
    check("rst_if_gnt", {63'd0, if_gnt}, 64'd0);
    check("rst_mem_read", {63'd0, mem_read}, 64'd0);
    check("rst_if_rdata", if_rdata, 64'd0);

    // Fetch read from address 5
    if_addr = 64'd5; reset_n = 1'b1; #1;
    check("f_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
    step(); if_req = 1'b0;
    check("f_busy1_rd", {62'd0, mem_read, mem_write}, 64'd2);
    check("f_busy1_addr", mem_address, 64'd5);
    check("f_busy1_wdata", mem_write_data, 64'd0);
    step();
    check("f_busy2_rd", {63'd0, mem_read}, 64'd1);
    check("f_busy2_rvalid", {63'd0, if_rvalid}, 64'd0);
    step();
    check("f_done_rvalid", {63'd0, if_rvalid}, 64'd1);
    check("f_done_rdata", if_rdata, 64'd5);
    check("f_done_memrd", {63'd0, mem_read}, 64'd0);
    check("f_done_addr", mem_address, 64'd0);
    step();
    check("f_idle_rvalid", {63'd0, if_rvalid}, 64'd0);

    // Data write 0xAA to address 7
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd7; d_wdata = 64'hAA; #1;
    check("w_gnt", {63'd0, d_gnt}, 64'd1);
    step(); d_req = 1'b0;
    check("w_busy1_ctl", {62'd0, mem_read, mem_write}, 64'd1);
    check("w_busy1_addr", mem_address, 64'd7);
    check("w_busy1_wdata", mem_write_data, 64'hAA);
    step();
    check("w_busy2_wr", {63'd0, mem_write}, 64'd1);
    check("w_busy2_wdata", mem_write_data, 64'hAA);
    step();
    check("w_done", {62'd0, d_done, if_rvalid}, 64'd2);
    check("w_rdata_kept", d_rdata, 64'd0);
    check("w_done_wr", {63'd0, mem_write}, 64'd0);
    step();
    check("w_idle_done", {63'd0, d_done}, 64'd0);

    // Data read from address 9
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd9; d_wdata = 64'hFF; #1;
    check("r_gnt", {63'd0, d_gnt}, 64'd1);
    step(); d_req = 1'b0;
    check("r_busy_ctl", {62'd0, mem_read, mem_write}, 64'd2);
    check("r_busy_wdata", mem_write_data, 64'd0);
    step(); step();
    check("r_done", {63'd0, d_done}, 64'd1);
    check("r_rdata", d_rdata, 64'd9);
    check("r_if_rdata_kept", if_rdata, 64'd5);
    step();

    // Reset in the first BUSY cycle
    if_req = 1'b1; if_addr = 64'h21; #1;
    check("rst_mid_gnt", {63'd0, if_gnt}, 64'd1);
    step(); if_req = 1'b0;
    check("rst_mid_busy", {63'd0, mem_read}, 64'd1);
    reset_n = 1'b0; #1;
    check("rst_mid_async", {63'd0, mem_read}, 64'd0);
    check("rst_mid_rdata", d_rdata, 64'd0);
    step();
    check("rst_mid_pulse1", {62'd0, if_rvalid, d_done}, 64'd0);
    step();
    check("rst_mid_pulse2", {62'd0, if_rvalid, d_done}, 64'd0);

    // Both ports requesting continuously; release reset with requests pending
    if_req = 1'b1; if_addr = 64'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h11;
    @(negedge clock); reset_n = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_data = (k % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      check($sformatf("arb_gnt%0d", k), {62'd0, d_gnt, if_gnt}, exp_data ? 64'd2 : 64'd1);
      step();
      if (k == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      check($sformatf("arb_addr%0d", k), mem_address, exp_data ? 64'h11 : 64'd3);
      step(); step();
      check($sformatf("arb_done_nogrant%0d", k), {62'd0, d_gnt, if_gnt}, 64'd0);
      step();
    end

    // Short data request during a fetch BUSY must be ignored
    if_req = 1'b1; if_addr = 64'h30; #1;
    check("drop_fgnt", {63'd0, if_gnt}, 64'd1);
    step(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h44; #1;
    check("drop_no_dgnt", {63'd0, d_gnt}, 64'd0);
    step(); d_req = 1'b0;
    check("drop_addr_b2", {63'd0, mem_address == 64'h44}, 64'd0);
    step();
    check("drop_rvalid", {62'd0, if_rvalid, d_done}, 64'd2);
    check("drop_if_rdata", if_rdata, 64'h30);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("drop_idle%0d", k),
            {61'd0, mem_address == 64'h44, mem_read, d_done}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
